io_cfg_ctrl: RTL

- Configuration controller for a bank of NUM_IO I/O blocks, each holding CFG_W config bits: TSMUX[1:0] in bits [2:1] and DORREG in bit [0].
- Keeps a shadow copy of every block's config. Accepts per-block write requests over a valid/ready handshake.
- After each accepted write, serially shifts the full shadow image into the I/O config scan chain, then pulses a load strobe.
- Sits between the fabric configuration port and the I/O ring.

---
 rtl/io_cfg_ctrl.sv | 68 ++++++
 1 files changed

// File: rtl/io_cfg_ctrl.sv
// io_cfg_ctrl: shadowed I/O block config with serial scan-chain push, load strobe and done/error pulses
module io_cfg_ctrl #(
  parameter int NUM_IO = 12,
  parameter int CFG_W  = 3,
  parameter int AW     = 4
) (
  input  logic             IOCLK,
  input  logic             RSTN,
  input  logic             REQ_VALID,
  input  logic [AW-1:0]    REQ_ADDR,
  input  logic [CFG_W-1:0] REQ_CFG,
  output logic             REQ_READY,
  input  logic [AW-1:0]    RD_ADDR,
  output logic [CFG_W-1:0] RD_CFG,
  output logic             CFG_SEN,
  output logic             CFG_SDO,
  output logic             CFG_LOAD,
  output logic             DONE,
  output logic             ERR,
  output logic             BUSY
);
  localparam int L  = NUM_IO * CFG_W;
  localparam int CW = $clog2(L);
  typedef enum logic [2:0] {INIT, IDLE, SHIFT, LOAD, FIN} state_t;
  state_t state_q, state_d;
  logic [NUM_IO-1:0][CFG_W-1:0] shadow_q, shadow_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic err_q, err_d;
  logic [L-1:0] img;
  logic [CW-1:0] idx;
  logic acc, in_rng, last;
  assign img       = shadow_q;
  assign idx       = CW'(L - 1) - cnt_q;
  assign last      = cnt_q == CW'(L - 1);
  assign in_rng    = 32'(REQ_ADDR) < NUM_IO;
  assign acc       = REQ_VALID && REQ_READY;
  assign REQ_READY = state_q == IDLE;
  assign BUSY      = state_q != IDLE;
  assign CFG_SEN   = state_q == SHIFT;
  assign CFG_SDO   = CFG_SEN && img[idx];
  assign CFG_LOAD  = state_q == LOAD;
  assign DONE      = state_q == FIN;
  assign ERR       = err_q;
  assign RD_CFG    = 32'(RD_ADDR) < NUM_IO ? shadow_q[RD_ADDR] : '0;
  always_comb begin
    shadow_d = shadow_q;
    state_d  = state_q == INIT  ? SHIFT :
               state_q == IDLE  ? (acc && in_rng ? SHIFT : IDLE) :
               state_q == SHIFT ? (last ? LOAD : SHIFT) :
               state_q == LOAD  ? FIN : IDLE;
    cnt_d    = state_q == SHIFT && !last ? cnt_q + 1'b1 : '0;
    err_d    = acc && !in_rng;
    if (acc && in_rng) shadow_d[REQ_ADDR] = REQ_CFG;
  end
  always_ff @(posedge IOCLK) begin
    if (!RSTN) begin
      state_q  <= INIT;
      shadow_q <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
    end
  end
endmodule
